// File: rtl/reg_load_arbiter_if.sv
// Bundle between requesters, reg_load_arbiter and the shared register.
// REG_LOAD_ARB_READBACK_EN adds the REG_DOUT readback input and the sticky ERR flag.
interface reg_load_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    REQ;
  logic [NREQ-1:0]    REQ_CLR;
  logic [NREQ*DW-1:0] REQ_DATA;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    ACK;
  logic               BUSY;
  logic [DW-1:0]      REG_DIN;
  logic               REG_LOADn;
  logic               REG_CLR;
`ifdef REG_LOAD_ARB_READBACK_EN
  logic [DW-1:0]      REG_DOUT;
  logic               ERR;

  modport master (
    output REQ, REQ_CLR, REQ_DATA, REG_DOUT,
    input  GNT, ACK, BUSY, REG_DIN, REG_LOADn, REG_CLR, ERR
  );
  modport slave (
    input  REQ, REQ_CLR, REQ_DATA, REG_DOUT,
    output GNT, ACK, BUSY, REG_DIN, REG_LOADn, REG_CLR, ERR
  );
`else
  modport master (
    output REQ, REQ_CLR, REQ_DATA,
    input  GNT, ACK, BUSY, REG_DIN, REG_LOADn, REG_CLR
  );
  modport slave (
    input  REQ, REQ_CLR, REQ_DATA,
    output GNT, ACK, BUSY, REG_DIN, REG_LOADn, REG_CLR
  );
`endif
endinterface

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one register between NREQ load/clear requesters.
// Optional REG_LOAD_ARB_READBACK_EN inserts a VERIFY state that checks REG_DOUT.
module reg_load_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input logic               CLK,
  input logic               RESETn,
  reg_load_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
`ifdef REG_LOAD_ARB_READBACK_EN
    S_VERIFY,
`endif
    S_ACK
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   win_reg, win_next;
  logic [IW-1:0]   last_reg, last_next;
  logic            clr_reg, clr_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic            busy_reg, busy_next;
  logic [DW-1:0]   din_reg, din_next;
  logic            loadn_reg, loadn_next;
  logic            strb_reg, strb_next;
`ifdef REG_LOAD_ARB_READBACK_EN
  logic            err_reg, err_next;
`endif

  logic [DW-1:0]     data_arr [NREQ];
  logic [2*NREQ-1:0] req2;
  logic [IW:0]       shamt;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic [IW-1:0]     pick;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_split
      assign data_arr[gi] = bus.REQ_DATA[gi*DW +: DW];
    end
  endgenerate

  // Rotate so bit 0 of rot is requester last+1; the lowest set bit wins.
  assign req2  = {bus.REQ, bus.REQ};
  assign shamt = {1'b0, last_reg} + 1'b1;
  assign rot   = NREQ'(req2 >> shamt);

  always_comb begin
    off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IW'(j);
    end
  end

  assign sum  = {1'b0, last_reg} + {1'b0, off} + 1'b1;
  assign pick = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    last_next  = last_reg;
    clr_next   = clr_reg;
    gnt_next   = gnt_reg;
    ack_next   = '0;
    busy_next  = busy_reg;
    din_next   = din_reg;
    loadn_next = 1'b1;
    strb_next  = 1'b0;
`ifdef REG_LOAD_ARB_READBACK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (|bus.REQ) begin
          state_next = S_SETUP;
          win_next   = pick;
          clr_next   = bus.REQ_CLR[pick];
          gnt_next   = NREQ'(1) << pick;
          busy_next  = 1'b1;
          din_next   = bus.REQ_CLR[pick] ? '0 : data_arr[pick];
        end
      end
      S_SETUP: begin
        state_next = S_STROBE;
        loadn_next = clr_reg;
        strb_next  = clr_reg;
      end
`ifdef REG_LOAD_ARB_READBACK_EN
      S_STROBE: state_next = S_VERIFY;
      S_VERIFY: begin
        state_next = S_ACK;
        ack_next   = gnt_reg;
        last_next  = win_reg;
        // din_reg already holds zero for a clear, so it is the expected readback.
        if (bus.REG_DOUT != din_reg) err_next = 1'b1;
      end
`else
      S_STROBE: begin
        state_next = S_ACK;
        ack_next   = gnt_reg;
        last_next  = win_reg;
      end
`endif
      S_ACK: begin
        state_next = S_IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_reg <= S_IDLE;
      win_reg   <= '0;
      last_reg  <= IW'(NREQ - 1);
      clr_reg   <= 1'b0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
      din_reg   <= '0;
      loadn_reg <= 1'b1;
      strb_reg  <= 1'b0;
`ifdef REG_LOAD_ARB_READBACK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      last_reg  <= last_next;
      clr_reg   <= clr_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      busy_reg  <= busy_next;
      din_reg   <= din_next;
      loadn_reg <= loadn_next;
      strb_reg  <= strb_next;
`ifdef REG_LOAD_ARB_READBACK_EN
      err_reg   <= err_next;
`endif
    end
  end

  assign bus.GNT       = gnt_reg;
  assign bus.ACK       = ack_reg;
  assign bus.BUSY      = busy_reg;
  assign bus.REG_DIN   = din_reg;
  assign bus.REG_LOADn = loadn_reg;
  assign bus.REG_CLR   = strb_reg;
`ifdef REG_LOAD_ARB_READBACK_EN
  assign bus.ERR       = err_reg;
`endif
endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench for reg_load_arbiter with a behavioural model of the shared register.
// Builds with or without REG_LOAD_ARB_READBACK_EN.
module tb_reg_load_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
`ifdef REG_LOAD_ARB_READBACK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  reg_load_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
  reg_load_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .CLK   (CLK),
    .RESETn(RESETn),
    .bus   (bus)
  );

  // Shared 8-bit register: clear wins over load.
  logic [7:0] reg_q = 8'h00;
  always @(posedge CLK) begin
    if (bus.REG_CLR) reg_q <= 8'h00;
    else if (!bus.REG_LOADn) reg_q <= bus.REG_DIN;
  end

`ifdef REG_LOAD_ARB_READBACK_EN
  logic force_zero = 1'b0;
  assign bus.REG_DOUT = force_zero ? 8'h00 : reg_q;
`endif

  typedef struct {
    logic [3:0] ack;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  clr;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [7:0]  val;
  } vec_t;
  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] ack, input logic [7:0] val);
    exp_t e;
    e.ack = ack;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_unexpected_ack"}, 32'(bus.ACK), 32'h0);
      return;
    end
    e = sb.pop_front();
    check({name, "_ack"}, 32'(bus.ACK), 32'(e.ack));
    check({name, "_gnt"}, 32'(bus.GNT), 32'(e.ack));
    check({name, "_reg"}, 32'(reg_q), 32'(e.val));
    check({name, "_din"}, 32'(bus.REG_DIN), 32'(e.val));
    $display("txn %s: ack=%b reg=%h", name, bus.ACK, reg_q);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!bus.BUSY) return;
    end
    check("idle_timeout", 32'(bus.BUSY), 32'h0);
  endtask

  task automatic wait_ack(output bit ok, output int ncyc, output int nload, output int nclr);
    ok = 1'b0; ncyc = 0; nload = 0; nclr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      ncyc++;
      if (!bus.REG_LOADn) nload++;
      if (bus.REG_CLR) nclr++;
      if (bus.ACK != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: no ACK within 20 cycles");
    end
  endtask

  task automatic run_txn(input string name, input logic [3:0] req, input logic [3:0] clr,
                         input logic [31:0] data, input logic [3:0] ea, input logic [7:0] ev);
    bit ok;
    int ncyc, nload, nclr;
    bit is_clr;
    is_clr = |(clr & ea);
    wait_idle();
    bus.REQ_CLR  = clr;
    bus.REQ_DATA = data;
    bus.REQ      = req;
    push_exp(ea, ev);
    wait_ack(ok, ncyc, nload, nclr);
    if (ok) begin
      sb_check(name);
      check({name, "_latency"}, 32'(ncyc), 32'(LAT));
      check({name, "_loadn_cycles"}, 32'(nload), is_clr ? 32'd0 : 32'd1);
      check({name, "_clr_cycles"}, 32'(nclr), is_clr ? 32'd1 : 32'd0);
`ifdef REG_LOAD_ARB_READBACK_EN
      check({name, "_err"}, 32'(bus.ERR), 32'(exp_err));
`endif
    end
    bus.REQ = '0;
    @(negedge CLK);
    check({name, "_busy_after"}, 32'(bus.BUSY), 32'h0);
    check({name, "_gnt_after"}, 32'(bus.GNT), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn  = 1'b0;
    bus.REQ = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ncyc, nload, nclr, nack;

    vecs[0] = '{req: 4'b0100, clr: 4'b0100, data: 32'h77777777, ack: 4'b0100, val: 8'h00};
    vecs[1] = '{req: 4'b1111, clr: 4'b0000, data: 32'h23222120, ack: 4'b1000, val: 8'h23};
    vecs[2] = '{req: 4'b1111, clr: 4'b0000, data: 32'h23222120, ack: 4'b0001, val: 8'h20};
    vecs[3] = '{req: 4'b0101, clr: 4'b0001, data: 32'h23222120, ack: 4'b0100, val: 8'h22};
    vecs[4] = '{req: 4'b0011, clr: 4'b0000, data: 32'h23222120, ack: 4'b0001, val: 8'h20};
    vecs[5] = '{req: 4'b0001, clr: 4'b0000, data: 32'h2322215C, ack: 4'b0001, val: 8'h5C};
    vecs[6] = '{req: 4'b1000, clr: 4'b1000, data: 32'h44332211, ack: 4'b1000, val: 8'h00};
    vecs[7] = '{req: 4'b0110, clr: 4'b0000, data: 32'h23222120, ack: 4'b0010, val: 8'h21};

    bus.REQ = '0; bus.REQ_CLR = '0; bus.REQ_DATA = '0;

    // Reset values
    do_reset();
    check("rst_gnt", 32'(bus.GNT), 32'h0);
    check("rst_ack", 32'(bus.ACK), 32'h0);
    check("rst_busy", 32'(bus.BUSY), 32'h0);
    check("rst_din", 32'(bus.REG_DIN), 32'h0);
    check("rst_loadn", 32'(bus.REG_LOADn), 32'h1);
    check("rst_clr", 32'(bus.REG_CLR), 32'h0);
`ifdef REG_LOAD_ARB_READBACK_EN
    check("rst_err", 32'(bus.ERR), 32'h0);
`endif

    // Cycle-by-cycle load of A5 by requester 0
    bus.REQ_CLR = '0; bus.REQ_DATA = 32'h000000A5; bus.REQ = 4'b0001;
    push_exp(4'b0001, 8'hA5);
    @(negedge CLK);
    check("t1_setup_gnt", 32'(bus.GNT), 32'h1);
    check("t1_setup_din", 32'(bus.REG_DIN), 32'hA5);
    check("t1_setup_busy", 32'(bus.BUSY), 32'h1);
    check("t1_setup_loadn", 32'(bus.REG_LOADn), 32'h1);
    @(negedge CLK);
    check("t1_strobe_loadn", 32'(bus.REG_LOADn), 32'h0);
    check("t1_strobe_clr", 32'(bus.REG_CLR), 32'h0);
    check("t1_strobe_ack", 32'(bus.ACK), 32'h0);
`ifdef REG_LOAD_ARB_READBACK_EN
    @(negedge CLK);
    check("t1_verify_loadn", 32'(bus.REG_LOADn), 32'h1);
    check("t1_verify_ack", 32'(bus.ACK), 32'h0);
`endif
    @(negedge CLK);
    sb_check("t1");
    check("t1_ack_loadn", 32'(bus.REG_LOADn), 32'h1);
    bus.REQ = '0;
    @(negedge CLK);
    check("t1_idle_gnt", 32'(bus.GNT), 32'h0);
    check("t1_idle_ack", 32'(bus.ACK), 32'h0);
    check("t1_idle_busy", 32'(bus.BUSY), 32'h0);

    // Table of single transactions; rotation continues from last=0
    for (int v = 0; v < 8; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].clr, vecs[v].data,
              vecs[v].ack, vecs[v].val);
    end

    // All four requesting continuously
    do_reset();
    bus.REQ_CLR = '0; bus.REQ_DATA = 32'h13121110; bus.REQ = 4'b1111;
    push_exp(4'b0001, 8'h10);
    push_exp(4'b0010, 8'h11);
    push_exp(4'b0100, 8'h12);
    push_exp(4'b1000, 8'h13);
    push_exp(4'b0001, 8'h10);
    for (int k = 0; k < 5; k++) begin
      wait_ack(ok, ncyc, nload, nclr);
      if (!ok) break;
      sb_check($sformatf("rr%0d", k));
      check($sformatf("rr%0d_spacing", k), 32'(ncyc), (k == 0) ? 32'(LAT) : 32'(LAT + 1));
      check($sformatf("rr%0d_loadn_cycles", k), 32'(nload), 32'd1);
    end
    bus.REQ = '0;

    // Data changed after capture must not affect the load
    wait_idle();
    wait_idle();
    bus.REQ_CLR = '0; bus.REQ_DATA = 32'h00003C00; bus.REQ = 4'b0010;
    push_exp(4'b0010, 8'h3C);
    @(negedge CLK);
    check("t4_setup_din", 32'(bus.REG_DIN), 32'h3C);
    bus.REQ_DATA = 32'h0000FF00;
    bus.REQ_CLR  = 4'b0010;
    wait_ack(ok, ncyc, nload, nclr);
    if (ok) begin
      sb_check("t4");
      check("t4_latency", 32'(ncyc), 32'(LAT - 1));
      check("t4_clr_cycles", 32'(nclr), 32'd0);
    end
    bus.REQ = '0;

    // Reset asserted during STROBE
    wait_idle();
    bus.REQ_CLR = '0; bus.REQ_DATA = 32'h00000099; bus.REQ = 4'b0001;
    @(negedge CLK);
    @(negedge CLK);
    check("t5_in_strobe", 32'(bus.REG_LOADn), 32'h0);
    RESETn  = 1'b0;
    bus.REQ = '0;
    @(negedge CLK);
    check("t5_gnt", 32'(bus.GNT), 32'h0);
    check("t5_loadn", 32'(bus.REG_LOADn), 32'h1);
    check("t5_busy", 32'(bus.BUSY), 32'h0);
    check("t5_ack", 32'(bus.ACK), 32'h0);
    check("t5_strobe_completed", 32'(reg_q), 32'h99);
    RESETn = 1'b1;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.ACK != '0) nack++;
    end
    check("t5_no_ack", 32'(nack), 32'h0);
    check("t5_sb_empty", 32'(sb.size()), 32'h0);

`ifdef REG_LOAD_ARB_READBACK_EN
    // Readback mismatch sets the sticky error
    force_zero = 1'b1;
    exp_err    = 1'b1;
    run_txn("rb_bad", 4'b0001, 4'b0000, 32'h0000005A, 4'b0001, 8'h5A);
    force_zero = 1'b0;
    run_txn("rb_good", 4'b0010, 4'b0000, 32'h00001100, 4'b0010, 8'h11);
    check("rb_err_sticky", 32'(bus.ERR), 32'h1);
    do_reset();
    check("rb_err_reset", 32'(bus.ERR), 32'h0);
    exp_err = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
